// File: rtl/cv32e40s_lockstep_alert_ctrl_if.sv
// Signal bundle between the dual-core compare logic, the safety manager and the alert controller.
// The slave side is the alert controller; the master side drives mismatch flags and acknowledges.
interface cv32e40s_lockstep_alert_ctrl_if #(
  parameter int NUM_STAGES = 3,
  parameter int CNT_W      = 8
);
  logic [NUM_STAGES-1:0] compare_err_i;
  logic                  alert_ack_i;
  logic                  reset_ack_i;
  logic                  alert_minor_o;
  logic                  alert_major_o;
  logic [NUM_STAGES-1:0] err_stage_o;
  logic [CNT_W-1:0]      err_cnt_o;
  logic                  fetch_en_gate_o;
  logic                  reset_req_o;
  logic [1:0]            state_o;

  modport slave (
    input  compare_err_i, alert_ack_i, reset_ack_i,
    output alert_minor_o, alert_major_o, err_stage_o, err_cnt_o,
           fetch_en_gate_o, reset_req_o, state_o
  );

  modport master (
    output compare_err_i, alert_ack_i, reset_ack_i,
    input  alert_minor_o, alert_major_o, err_stage_o, err_cnt_o,
           fetch_en_gate_o, reset_req_o, state_o
  );
endinterface

// File: rtl/cv32e40s_lockstep_alert_ctrl.sv
// Turns lockstep compare mismatches into minor alerts, sticky diagnosis and an escalation to fetch
// gating plus a reset request.
//   state    | meaning
//   IDLE     | no outstanding alert, fetch allowed
//   ALERT    | minor alert raised, ack timer running, fetch allowed
//   ESCALATE | fetch gated, reset requested until reset_ack_i
//   LOCKED   | fetch gated, terminal until rst_ni
module cv32e40s_lockstep_alert_ctrl #(
  parameter int NUM_STAGES    = 3,
  parameter int ESC_THRESHOLD = 4,
  parameter int ACK_TIMEOUT   = 256,
  parameter int CNT_W         = 8
) (
  input logic clk_i,
  input logic rst_ni,
  cv32e40s_lockstep_alert_ctrl_if.slave bus
);
  localparam int TMR_W = $clog2(ACK_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W:0]   ESC_THR  = (CNT_W+1)'(ESC_THRESHOLD);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ALERT    = 2'd1,
    ST_ESCALATE = 2'd2,
    ST_LOCKED   = 2'd3
  } state_e;

  state_e                r_state, w_state_nxt;
  logic [TMR_W-1:0]      r_timer, w_timer_nxt;
  logic                  r_err_any_q;
  logic                  r_minor;
  logic [CNT_W-1:0]      r_cnt;
  logic [NUM_STAGES-1:0] r_stage;

  logic                  w_err_any;
  logic                  w_event;
  logic [CNT_W:0]        w_cnt_p1;
  logic                  w_esc_hit;

  assign w_err_any = |bus.compare_err_i;
  assign w_event   = w_err_any & ~r_err_any_q;
  // One extra bit so the threshold compare still works once the counter is saturated.
  assign w_cnt_p1  = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_esc_hit = w_event && (w_cnt_p1 >= ESC_THR);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_err_any_q <= 1'b0;
      r_minor     <= 1'b0;
      r_cnt       <= '0;
      r_stage     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_err_any_q <= w_err_any;
      r_minor     <= w_event;
      r_stage     <= r_stage | bus.compare_err_i;
      if (w_event && (r_cnt != CNT_MAX)) begin
        r_cnt <= w_cnt_p1[CNT_W-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    case (r_state)
      ST_IDLE: begin
        if (w_esc_hit) begin
          w_state_nxt = ST_ESCALATE;
        end else if (w_event) begin
          w_state_nxt = ST_ALERT;
          w_timer_nxt = TMR_LOAD;
        end
      end
      ST_ALERT: begin
        // A fresh event outranks an ack arriving in the same cycle.
        if (w_esc_hit) begin
          w_state_nxt = ST_ESCALATE;
        end else if (w_event) begin
          w_timer_nxt = TMR_LOAD;
        end else if (bus.alert_ack_i) begin
          w_state_nxt = ST_IDLE;
        end else if (r_timer == '0) begin
          w_state_nxt = ST_ESCALATE;
        end else begin
          w_timer_nxt = r_timer - TMR_ONE;
        end
      end
      ST_ESCALATE: begin
        if (bus.reset_ack_i) begin
          w_state_nxt = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        w_state_nxt = ST_LOCKED;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.alert_minor_o   = r_minor;
  assign bus.alert_major_o   = (r_state == ST_ESCALATE) || (r_state == ST_LOCKED);
  assign bus.fetch_en_gate_o = (r_state == ST_IDLE) || (r_state == ST_ALERT);
  assign bus.reset_req_o     = (r_state == ST_ESCALATE);
  assign bus.err_stage_o     = r_stage;
  assign bus.err_cnt_o       = r_cnt;
  assign bus.state_o         = r_state;
endmodule

// File: tb/tb_cv32e40s_lockstep_alert_ctrl.sv
// Scenario bench for the lockstep alert controller; expected outputs are queued as stimulus is
// driven and compared one cycle later.
module tb_cv32e40s_lockstep_alert_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cv32e40s_lockstep_alert_ctrl_if #(.NUM_STAGES(3), .CNT_W(8)) bus ();

  cv32e40s_lockstep_alert_ctrl #(
    .NUM_STAGES(3), .ESC_THRESHOLD(4), .ACK_TIMEOUT(256), .CNT_W(8)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       minor;
    logic [7:0] cnt;
    logic [2:0] stage;
    logic [1:0] state;
    logic       gate;
    logic       major;
    logic       rreq;
  } obs_t;

  obs_t       sb[$];
  obs_t       got, exp_v;
  logic [7:0] e_cnt;
  logic [2:0] e_stage;

  function automatic obs_t mk(input logic minor, input logic [1:0] st);
    obs_t o;
    o.minor = minor;
    o.cnt   = e_cnt;
    o.stage = e_stage;
    o.state = st;
    o.gate  = (st == 2'd0) || (st == 2'd1);
    o.major = (st == 2'd2) || (st == 2'd3);
    o.rreq  = (st == 2'd2);
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.minor = bus.alert_minor_o;
    o.cnt   = bus.err_cnt_o;
    o.stage = bus.err_stage_o;
    o.state = bus.state_o;
    o.gate  = bus.fetch_en_gate_o;
    o.major = bus.alert_major_o;
    o.rreq  = bus.reset_req_o;
    return o;
  endfunction

  task automatic step(input logic [2:0] err, input logic ack, input logic rack);
    bus.compare_err_i = err;
    bus.alert_ack_i   = ack;
    bus.reset_ack_i   = rack;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bus.compare_err_i = '0;
    bus.alert_ack_i   = 1'b0;
    bus.reset_ack_i   = 1'b0;
    rst_n   = 1'b0;
    e_cnt   = '0;
    e_stage = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.compare_err_i = '0;
    bus.alert_ack_i   = 1'b0;
    bus.reset_ack_i   = 1'b0;
    rst_n   = 1'b0;
    e_cnt   = '0;
    e_stage = '0;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(mk(1'b0, 2'd0));
    exp_v = sb.pop_front(); got = observe(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL reset_hold got=%h exp=%h", got, exp_v); end
    rst_n = 1'b1;
    sb.push_back(mk(1'b0, 2'd0));
    step(3'b000, 1'b0, 1'b0);
    exp_v = sb.pop_front(); got = observe(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL reset_release got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_single_event();
    apply_reset();
    e_cnt = 8'd1; e_stage = 3'b010;
    sb.push_back(mk(1'b1, 2'd1));
    step(3'b010, 1'b0, 1'b0);
    exp_v = sb.pop_front(); got = observe(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL single_evt got=%h exp=%h", got, exp_v); end
    for (int i = 0; i < 5; i++) begin
      sb.push_back(mk(1'b0, 2'd1));
      step(3'b000, 1'b0, 1'b0);
      exp_v = sb.pop_front(); got = observe(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL single_wait%0d got=%h exp=%h", i, got, exp_v); end
    end
    sb.push_back(mk(1'b0, 2'd0));
    step(3'b000, 1'b1, 1'b0);
    exp_v = sb.pop_front(); got = observe(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL single_ack got=%h exp=%h", got, exp_v); end
    sb.push_back(mk(1'b0, 2'd0));
    step(3'b000, 1'b0, 1'b0);
    exp_v = sb.pop_front(); got = observe(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL single_idle got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_held();
    apply_reset();
    e_stage = 3'b001;
    for (int i = 0; i < 10; i++) begin
      e_cnt = 8'd1;
      sb.push_back(mk(i == 0, 2'd1));
      step(3'b001, 1'b0, 1'b0);
      exp_v = sb.pop_front(); got = observe(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL held%0d got=%h exp=%h", i, got, exp_v); end
    end
    sb.push_back(mk(1'b0, 2'd1));
    step(3'b000, 1'b0, 1'b0);
    exp_v = sb.pop_front(); got = observe(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL held_release got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_timeout();
    apply_reset();
    e_cnt = 8'd1; e_stage = 3'b100;
    sb.push_back(mk(1'b1, 2'd1));
    step(3'b100, 1'b0, 1'b0);
    exp_v = sb.pop_front(); got = observe(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL tmo_evt got=%h exp=%h", got, exp_v); end
    for (int i = 0; i < 255; i++) begin
      sb.push_back(mk(1'b0, 2'd1));
      step(3'b000, 1'b0, 1'b0);
      exp_v = sb.pop_front(); got = observe(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL tmo_alert%0d got=%h exp=%h", i, got, exp_v); end
    end
    sb.push_back(mk(1'b0, 2'd2));
    step(3'b000, 1'b0, 1'b0);
    exp_v = sb.pop_front(); got = observe(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL tmo_esc got=%h exp=%h", got, exp_v); end
    sb.push_back(mk(1'b0, 2'd2));
    step(3'b000, 1'b1, 1'b0);
    exp_v = sb.pop_front(); got = observe(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL esc_ignore_ack got=%h exp=%h", got, exp_v); end
    sb.push_back(mk(1'b0, 2'd3));
    step(3'b000, 1'b0, 1'b1);
    exp_v = sb.pop_front(); got = observe(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL tmo_locked got=%h exp=%h", got, exp_v); end
    e_cnt = 8'd2; e_stage = 3'b101;
    sb.push_back(mk(1'b1, 2'd3));
    step(3'b001, 1'b0, 1'b0);
    exp_v = sb.pop_front(); got = observe(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL locked_evt got=%h exp=%h", got, exp_v); end
    sb.push_back(mk(1'b0, 2'd3));
    step(3'b000, 1'b1, 1'b0);
    exp_v = sb.pop_front(); got = observe(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL locked_stay got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_event_ack_same();
    apply_reset();
    e_cnt = 8'd1; e_stage = 3'b001;
    sb.push_back(mk(1'b1, 2'd1));
    step(3'b001, 1'b0, 1'b0);
    exp_v = sb.pop_front(); got = observe(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL ea_first got=%h exp=%h", got, exp_v); end
    sb.push_back(mk(1'b0, 2'd1));
    step(3'b000, 1'b0, 1'b0);
    exp_v = sb.pop_front(); got = observe(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL ea_gap got=%h exp=%h", got, exp_v); end
    e_cnt = 8'd2; e_stage = 3'b101;
    sb.push_back(mk(1'b1, 2'd1));
    step(3'b100, 1'b1, 1'b0);
    exp_v = sb.pop_front(); got = observe(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL ea_same got=%h exp=%h", got, exp_v); end
    for (int i = 0; i < 255; i++) begin
      sb.push_back(mk(1'b0, 2'd1));
      step(3'b000, 1'b0, 1'b0);
      exp_v = sb.pop_front(); got = observe(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL ea_reload%0d got=%h exp=%h", i, got, exp_v); end
    end
    sb.push_back(mk(1'b0, 2'd2));
    step(3'b000, 1'b0, 1'b0);
    exp_v = sb.pop_front(); got = observe(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL ea_esc got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_threshold_and_saturation();
    logic [2:0] pat [3];
    pat[0] = 3'b001; pat[1] = 3'b100; pat[2] = 3'b010;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      e_cnt = e_cnt + 8'd1; e_stage = e_stage | pat[k];
      sb.push_back(mk(1'b1, 2'd1));
      step(pat[k], 1'b0, 1'b0);
      exp_v = sb.pop_front(); got = observe(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL thr_evt%0d got=%h exp=%h", k, got, exp_v); end
      sb.push_back(mk(1'b0, 2'd0));
      step(3'b000, 1'b1, 1'b0);
      exp_v = sb.pop_front(); got = observe(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL thr_ack%0d got=%h exp=%h", k, got, exp_v); end
    end
    e_cnt = 8'd4; e_stage = 3'b111;
    sb.push_back(mk(1'b1, 2'd2));
    step(3'b001, 1'b0, 1'b1);
    exp_v = sb.pop_front(); got = observe(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL thr_esc got=%h exp=%h", got, exp_v); end
    sb.push_back(mk(1'b0, 2'd3));
    step(3'b000, 1'b0, 1'b1);
    exp_v = sb.pop_front(); got = observe(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL thr_locked got=%h exp=%h", got, exp_v); end
    for (int i = 0; i < 260; i++) begin
      if (e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
      sb.push_back(mk(1'b1, 2'd3));
      step(3'b010, 1'b0, 1'b0);
      exp_v = sb.pop_front(); got = observe(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL sat_evt%0d got=%h exp=%h", i, got, exp_v); end
      sb.push_back(mk(1'b0, 2'd3));
      step(3'b000, 1'b0, 1'b0);
      exp_v = sb.pop_front(); got = observe(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL sat_gap%0d got=%h exp=%h", i, got, exp_v); end
    end
  endtask

  task automatic test_async_reset_locked();
    // Enter mid-cycle so only the asynchronous path can clear the outputs.
    #2;
    rst_n = 1'b0;
    e_cnt = '0; e_stage = '0;
    #1;
    sb.push_back(mk(1'b0, 2'd0));
    exp_v = sb.pop_front(); got = observe(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL async_rst got=%h exp=%h", got, exp_v); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.push_back(mk(1'b0, 2'd0));
    step(3'b000, 1'b0, 1'b0);
    exp_v = sb.pop_front(); got = observe(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL async_rst_release got=%h exp=%h", got, exp_v); end
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_held();
    test_timeout();
    test_event_ack_same();
    test_threshold_and_saturation();
    test_async_reset_locked();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
